// File: rtl/interface_wheel_counter.sv
// rtl/interface_wheel_counter.sv - quadrature wheel counter with glitch filter, x4 decode and optional velocity
// Optional velocity window enabled by defining WHEEL_VELOCITY_EN.
module interface_wheel_counter #(
  parameter int WIDTH      = 16,
  parameter int FILTER_LEN = 3,
  parameter int SAT_MODE   = 0,
  parameter int WINDOW     = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             ovf,
  output logic [WIDTH-1:0] velocity,
  output logic             vel_valid
);

  localparam logic [WIDTH-1:0] MAX_VAL   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [3:0]       RUN_LAST  = 4'(FILTER_LEN - 1);
  localparam logic [4:0]       PRIME_LEN = 5'(FILTER_LEN + 2);

  logic [1:0] sync1, sync2;   // bit 1 = A, bit 0 = B
  logic [1:0] filt, filt_next;
  logic [3:0] run_a, run_b;
  logic [4:0] prime_cnt;
  logic       primed;
  logic [1:0] delta;
  logic       step_cw, step_ccw, illegal;
  logic       at_max, at_min;

  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    case (g)
      2'b00:   gray_pos = 2'd0;
      2'b01:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  // A channel flips on the same edge its mismatch run reaches FILTER_LEN,
  // so the decoder sees the new level without an extra register stage.
  always_comb begin
    filt_next = filt;
    if (sync2[1] != filt[1] && run_a == RUN_LAST) filt_next[1] = sync2[1];
    if (sync2[0] != filt[0] && run_b == RUN_LAST) filt_next[0] = sync2[0];
  end

  assign primed   = (prime_cnt == PRIME_LEN);
  assign delta    = gray_pos(filt_next) - gray_pos(filt);
  assign step_cw  = primed && (delta == 2'd1);
  assign step_ccw = primed && (delta == 2'd3);
  assign illegal  = primed && (delta == 2'd2);
  assign at_max   = (count == MAX_VAL);
  assign at_min   = (count == MIN_VAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      filt      <= 2'b00;
      run_a     <= 4'd0;
      run_b     <= 4'd0;
      prime_cnt <= 5'd0;
      count     <= '0;
      dir       <= 1'b0;
      step      <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      sync1 <= {enc_a, enc_b};
      sync2 <= sync1;
      filt  <= filt_next;
      run_a <= (sync2[1] != filt[1] && run_a != RUN_LAST) ? run_a + 4'd1 : 4'd0;
      run_b <= (sync2[0] != filt[0] && run_b != RUN_LAST) ? run_b + 4'd1 : 4'd0;
      // Until the pipeline has settled, filtered levels are adopted silently.
      if (!primed) prime_cnt <= prime_cnt + 5'd1;

      step <= step_cw | step_ccw;
      if (step_cw | step_ccw) dir <= step_cw;

      if (clear)        err <= 1'b0;
      else if (illegal) err <= 1'b1;

      if (clear) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if (load) begin
        count <= load_value;
      end else if (step_cw) begin
        if (at_max) begin
          ovf   <= 1'b1;
          count <= (SAT_MODE != 0) ? count : MIN_VAL;
        end else begin
          count <= count + ONE;
        end
      end else if (step_ccw) begin
        if (at_min) begin
          ovf   <= 1'b1;
          count <= (SAT_MODE != 0) ? count : MAX_VAL;
        end else begin
          count <= count - ONE;
        end
      end
    end
  end

`ifdef WHEEL_VELOCITY_EN
  localparam int                WCW      = $clog2(WINDOW);
  localparam logic [WCW-1:0]    WIN_LAST = WCW'(WINDOW - 1);
  localparam logic [WCW-1:0]    WIN_ONE  = WCW'(1);

  logic [WCW-1:0]   win_cnt;
  logic [WIDTH-1:0] acc, acc_next;

  always_comb begin
    acc_next = acc;
    if (step_cw)       acc_next = acc + ONE;
    else if (step_ccw) acc_next = acc - ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt   <= '0;
      acc       <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (win_cnt == WIN_LAST) begin
        velocity  <= acc_next;
        vel_valid <= 1'b1;
        acc       <= '0;
        win_cnt   <= '0;
      end else begin
        acc     <= acc_next;
        win_cnt <= win_cnt + WIN_ONE;
      end
    end
  end
`else
  assign velocity  = '0;
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_interface_wheel_counter.sv
// tb/tb_interface_wheel_counter.sv - randomized self-checking bench for interface_wheel_counter
// Wrap and saturating instances share stimulus; velocity checks depend on WHEEL_VELOCITY_EN.
module tb_interface_wheel_counter;
  localparam int W   = 8;
  localparam int FL  = 3;
  localparam int WIN = 100;

  logic         clk = 1'b0, reset = 1'b0, enc_a = 1'b0, enc_b = 1'b0, clear = 1'b0, load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count0, count1, vel0, vel1;
  logic         dir0, dir1, step0, step1, err0, err1, ovf0, ovf1, vv0, vv1;

  int checks = 0, fails = 0, cyc = 0, nstep = 0;
  int cur_pos = 0, m_wrap = 0, m_sat = 0;
  logic m_ovf0 = 1'b0, m_ovf1 = 1'b0;

  interface_wheel_counter #(.WIDTH(W), .FILTER_LEN(FL), .SAT_MODE(0), .WINDOW(WIN)) u_wrap (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear), .load(load),
    .load_value(load_value), .count(count0), .dir(dir0), .step(step0), .err(err0), .ovf(ovf0),
    .velocity(vel0), .vel_valid(vv0));

  interface_wheel_counter #(.WIDTH(W), .FILTER_LEN(FL), .SAT_MODE(1), .WINDOW(WIN)) u_sat (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear), .load(load),
    .load_value(load_value), .count(count1), .dir(dir1), .step(step1), .err(err1), .ovf(ovf1),
    .velocity(vel1), .vel_valid(vv1));

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) if (step0) nstep = nstep + 1;

  function automatic logic [1:0] gray(input int p);
    case (p & 3)
      0:       gray = 2'b00;
      1:       gray = 2'b01;
      2:       gray = 2'b11;
      default: gray = 2'b10;
    endcase
  endfunction

  // Position arithmetic on plain integers: wrap model and clamp model.
  task automatic model_step(input int d);
    m_wrap = m_wrap + d;
    if (m_wrap > 127)  begin m_wrap = m_wrap - 256; m_ovf0 = 1'b1; end
    if (m_wrap < -128) begin m_wrap = m_wrap + 256; m_ovf0 = 1'b1; end
    if (m_sat + d > 127 || m_sat + d < -128) m_ovf1 = 1'b1;
    else m_sat = m_sat + d;
  endtask

  task automatic model_zero();
    m_wrap = 0; m_sat = 0; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
  endtask

  task automatic move(input int d, input int gap);
    @(negedge clk);
    cur_pos = cur_pos + d;
    {enc_a, enc_b} = gray(cur_pos);
    model_step(d);
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; clear = 1'b0; load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    cur_pos = 0;
    model_zero();
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({count0, dir0, step0, err0, ovf0, vel0, vv0} !== '0) begin
      fails++;
      $display("FAIL reset_state count=%0d dir=%b step=%b err=%b ovf=%b vel=%0d vv=%b required all 0",
               count0, dir0, step0, err0, ovf0, vel0, vv0);
    end
    do_reset();
    @(negedge clk) begin load = 1'b1; load_value = 8'd33; end
    @(negedge clk) load = 1'b0;
    #1;
    checks++;
    if (count0 !== 8'd33) begin
      fails++; $display("FAIL load_basic count=%0d required 33", count0);
    end
    // Reset arriving mid-filter and away from any clock edge.
    @(negedge clk) enc_a = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({count0, dir0, step0, err0, ovf0} !== '0) begin
      fails++; $display("FAIL async_reset count=%0d dir=%b step=%b required 0", count0, dir0, step0);
    end
    do_reset();
  endtask

  task automatic test_cw_sequence();
    int base, found, hits;
    base = nstep;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cur_pos = cur_pos + 1;
      {enc_a, enc_b} = gray(cur_pos);
      model_step(1);
      found = -1; hits = 0;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (step0) begin hits++; if (found < 0) found = k; end
      end
      checks++;
      if (found !== 5 || hits !== 1) begin
        fails++; $display("FAIL step_latency idx=%0d edge=%0d pulses=%0d required edge 5 pulses 1", i, found, hits);
      end
    end
    checks++;
    if (count0 !== 8'd8 || dir0 !== 1'b1 || count1 !== 8'd8) begin
      fails++; $display("FAIL cw_count count=%0d sat=%0d dir=%b required 8 8 1", count0, count1, dir0);
    end
    checks++;
    if (nstep - base !== 8) begin
      fails++; $display("FAIL cw_pulses got=%0d required 8", nstep - base);
    end
  endtask

  task automatic test_glitch();
    int base;
    base = nstep;
    @(negedge clk) enc_a = ~enc_a;
    @(negedge clk);
    @(negedge clk) enc_a = ~enc_a;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (count0 !== 8'(m_wrap) || nstep !== base) begin
      fails++; $display("FAIL glitch_reject count=%0d steps=%0d required %0d 0", count0, nstep - base, m_wrap);
    end
    move(-1, 10);
    checks++;
    if (count0 !== 8'(m_wrap) || nstep - base !== 1 || dir0 !== 1'b0) begin
      fails++; $display("FAIL stable_accept count=%0d steps=%0d dir=%b required %0d 1 0",
                        count0, nstep - base, dir0, m_wrap);
    end
  endtask

  task automatic test_illegal();
    int base;
    if (gray(cur_pos) != 2'b00) move(1, 10);
    base = nstep;
    @(negedge clk) {enc_a, enc_b} = 2'b11;
    cur_pos = cur_pos + 2;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (err0 !== 1'b1 || count0 !== 8'(m_wrap) || nstep !== base) begin
      fails++; $display("FAIL illegal_jump err=%b count=%0d steps=%0d required 1 %0d 0",
                        err0, count0, nstep - base, m_wrap);
    end
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    #1;
    model_zero();
    checks++;
    if (err0 !== 1'b0 || count0 !== 8'd0) begin
      fails++; $display("FAIL clear_err err=%b count=%0d required 0 0", err0, count0);
    end
  endtask

  task automatic test_overflow();
    @(negedge clk) begin load = 1'b1; load_value = 8'd127; end
    @(negedge clk) load = 1'b0;
    m_wrap = 127; m_sat = 127;
    #1;
    checks++;
    if (ovf0 !== 1'b0 || ovf1 !== 1'b0 || count1 !== 8'd127) begin
      fails++; $display("FAIL ovf_preload ovf0=%b ovf1=%b sat=%0d required 0 0 127", ovf0, ovf1, count1);
    end
    move(1, 10);
    checks++;
    if (count0 !== 8'h80 || ovf0 !== 1'b1) begin
      fails++; $display("FAIL wrap_ovf count=%0d ovf=%b required -128 1", $signed(count0), ovf0);
    end
    checks++;
    if (count1 !== 8'h7f || ovf1 !== 1'b1) begin
      fails++; $display("FAIL sat_ovf count=%0d ovf=%b required 127 1", $signed(count1), ovf1);
    end
    move(-1, 10);
    checks++;
    if (count0 !== 8'h7f || count1 !== 8'h7e) begin
      fails++; $display("FAIL wrap_back wrap=%0d sat=%0d required 127 126", count0, count1);
    end
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    model_zero();
  endtask

  task automatic test_priority();
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      cur_pos = cur_pos - 1;
      {enc_a, enc_b} = gray(cur_pos);
      repeat (4) @(posedge clk);
      @(negedge clk) begin load = 1'b1; load_value = 8'd50; clear = (pass == 1); end
      @(posedge clk); #1;
      checks++;
      if (step0 !== 1'b1 || dir0 !== 1'b0 || count0 !== ((pass == 1) ? 8'd0 : 8'd50)) begin
        fails++; $display("FAIL load_step_priority pass=%0d step=%b dir=%b count=%0d required 1 0 %0d",
                          pass, step0, dir0, count0, (pass == 1) ? 0 : 50);
      end
      @(negedge clk) begin load = 1'b0; clear = 1'b0; end
      m_wrap = (pass == 1) ? 0 : 50; m_sat = m_wrap;
      if (pass == 1) begin m_ovf0 = 1'b0; m_ovf1 = 1'b0; end
      repeat (8) @(posedge clk);
    end
  endtask

  task automatic test_random();
    int base, op, gap, d;
    logic signed [W-1:0] v;
    base = nstep;
    d = 0;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
        case ($urandom_range(0, 2))
          0:       v = 8'sd126;
          1:       v = -8'sd127;
          default: v = W'($urandom);
        endcase
        @(negedge clk) begin load = 1'b1; load_value = v; end
        @(negedge clk) load = 1'b0;
        m_wrap = v; m_sat = v;
        #1;
      end else if (op == 1) begin
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        model_zero();
        #1;
      end else begin
        gap = $urandom_range(6, 12);
        move(($urandom_range(0, 1) == 1) ? 1 : -1, gap);
        d++;
      end
      checks++;
      if (count0 !== 8'(m_wrap) || ovf0 !== m_ovf0) begin
        fails++; $display("FAIL random_wrap i=%0d count=%0d ovf=%b required %0d %b",
                          i, $signed(count0), ovf0, m_wrap, m_ovf0);
      end
      checks++;
      if (count1 !== 8'(m_sat) || ovf1 !== m_ovf1) begin
        fails++; $display("FAIL random_sat i=%0d count=%0d ovf=%b required %0d %b",
                          i, $signed(count1), ovf1, m_sat, m_ovf1);
      end
    end
    checks++;
    if (nstep - base !== d) begin
      fails++; $display("FAIL random_pulses got=%0d required %0d", nstep - base, d);
    end
  endtask

  task automatic test_velocity();
    int seen;
    do_reset();
    for (int i = 0; i < 6; i++) move(1, 8);
    for (int i = 0; i < 2; i++) move(-1, 8);
    seen = -1;
    for (int k = 0; k < 200 && seen < 0; k++) begin
      @(posedge clk); #1;
      if (vv0) seen = cyc;
    end
`ifdef WHEEL_VELOCITY_EN
    checks++;
    if (seen !== WIN || vel0 !== 8'd4) begin
      fails++; $display("FAIL velocity_window cycle=%0d vel=%0d required %0d 4", seen, $signed(vel0), WIN);
    end
`else
    checks++;
    if (seen !== -1 || vel0 !== 8'd0) begin
      fails++; $display("FAIL velocity_disabled cycle=%0d vel=%0d required none 0", seen, vel0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cw_sequence();
    test_glitch();
    test_illegal();
    test_overflow();
    test_priority();
    test_random();
    test_velocity();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/interface_wheel_counter.md
INTERFACE_WHEEL_COUNTER -- requirements
Module: interface_wheel_counter

Interface
REQ-001 Parameter WIDTH, default 16: width of the signed two's-complement position count.
REQ-002 Parameter FILTER_LEN, default 3, range 1..15: consecutive stable cycles required before an encoder level is accepted.
REQ-003 Parameter SAT_MODE, default 0: 0 = count wraps, 1 = count saturates.
REQ-004 Parameter WINDOW, default 1000, minimum 2: velocity sample window in clk cycles.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 enc_a  input  1  encoder channel A; asynchronous to clk.
REQ-008 enc_b  input  1  encoder channel B; asynchronous to clk.
REQ-009 clear  input  1  synchronous clear of count, err and ovf.
REQ-010 load  input  1  synchronous load of load_value into count.
REQ-011 load_value  input  WIDTH  signed preset value.
REQ-012 count  output  WIDTH  signed position count.
REQ-013 dir  output  1  direction of the last accepted step: 1 = CW, 0 = CCW.
REQ-014 step  output  1  one-cycle pulse for each accepted step.
REQ-015 err  output  1  sticky illegal-transition flag.
REQ-016 ovf  output  1  sticky overflow/saturation flag.
REQ-017 velocity  output  WIDTH  signed net step count over the last window.
REQ-018 vel_valid  output  1  one-cycle pulse when velocity is updated.

Function
REQ-019 Each of enc_a and enc_b SHALL pass through a 2-flop synchronizer.
REQ-020 Glitch filter: the filtered level SHALL take the synchronized value only after that value has differed from the filtered level for FILTER_LEN consecutive cycles; any mismatch run that is interrupted resets the run counter.
REQ-021 The decoder SHALL track the Gray sequence {A,B} 00->01->11->10->00 (CW, +1) and its reverse (CCW, -1); one step per filtered edge (x4 decoding).
REQ-022 If both filtered bits change in the same cycle, the block SHALL set err, leave count unchanged, emit no step and adopt the new state.
REQ-023 Latency: count, step and dir SHALL update on the (FILTER_LEN+2)th rising edge after the edge that first samples the new input level.
REQ-024 Priority within a cycle SHALL be clear > load > step. A step coinciding with clear or load SHALL be discarded, but step and dir still pulse.
REQ-025 SAT_MODE=0: count wraps modulo 2^WIDTH; ovf is set on a wrap in either direction.
REQ-026 SAT_MODE=1: count holds at +(2^(WIDTH-1)-1) or -2^(WIDTH-1); ovf is set on any attempted step beyond either limit.
REQ-027 clear SHALL zero count, err and ovf. load SHALL only set count and does not alter the flags.
REQ-028 The first filtered level after reset release SHALL be adopted as the decoder state without counting or setting err.

Reset
REQ-029 Asserting reset, including mid-step or mid-filter, SHALL immediately force the following to 0:
- count, dir, step, err, ovf, velocity, vel_valid;
- the synchronizers, filter run counters and window counter.

Configuration
REQ-030 With macro WHEEL_VELOCITY_EN defined, the block SHALL:
- accumulate signed net accepted steps over each WINDOW-cycle window;
- at the window's last cycle, copy the total to velocity (wrapping to WIDTH bits), pulse vel_valid and restart the accumulator;
- ignore clear and load for velocity purposes.
REQ-031 With WHEEL_VELOCITY_EN undefined, velocity and vel_valid SHALL be driven constant 0 and no window logic SHALL be present.

Verification
REQ-032 Reset, then 8 CW Gray transitions on A/B spaced 10 cycles apart -> count=8, dir=1, 8 step pulses, each 5 edges after its sampling edge.
REQ-033 A 2-cycle pulse on enc_a with FILTER_LEN=3 -> no step, count unchanged; a 3-cycle-stable level -> one step.
REQ-034 Filtered {A,B} 00->11 -> err=1, count unchanged; then clear -> err=0, count=0.
REQ-035 WIDTH=8, load=127, one CW step: SAT_MODE=0 -> count=-128, ovf=1; SAT_MODE=1 -> count=127, ovf=1.
REQ-036 load=50 in the same cycle as an accepted CCW step -> count=50; with clear also high -> count=0.
REQ-037 WHEEL_VELOCITY_EN, WINDOW=100, 6 CW then 2 CCW steps within one window -> vel_valid pulse at cycle 100, velocity=4.
